// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles little-endian 32-bit words from a byte stream and
// writes each one over an AXI4-Lite write channel into a staging buffer, stopping
// on a terminator word, a bad write response or when the buffer is full.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
  parameter int          MAX_WORDS      = 1024,
  parameter logic [31:0] STOP_SIGNATURE = 32'hBDEDE000
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        loader_done,
  output logic        loader_error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    COLLECT,
    WRITE,
    B_WAIT,
    DONE,
    ERROR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        rx_fire;
  logic        aw_fire;
  logic        w_fire;
  logic        b_fire;
  logic        aw_settled;
  logic        w_settled;
  logic        enter_write;
  logic [16:0] count_inc;
  logic        buffer_full;

  // Full strobes: the loader only ever writes whole words.
  assign m_axi_wstrb = 4'b1111;

  assign rx_fire  = rx_valid && rx_ready;
  assign aw_fire  = m_axi_awvalid && m_axi_awready;
  assign w_fire   = m_axi_wvalid && m_axi_wready;
  assign b_fire   = m_axi_bvalid && m_axi_bready;

  // A channel is settled once its valid has already dropped or handshakes now.
  assign aw_settled = !m_axi_awvalid || aw_fire;
  assign w_settled  = !m_axi_wvalid || w_fire;

  assign enter_write = (state_q == COLLECT) && (state_d == WRITE);

  // Widened so the comparison against MAX_WORDS cannot wrap at 65535.
  assign count_inc   = {1'b0, word_count} + 17'd1;
  assign buffer_full = (count_inc == 17'(MAX_WORDS));

  // Next-state decode for the loader sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (rx_fire && (byte_cnt == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        if (aw_settled && w_settled) state_d = B_WAIT;
      end
      B_WAIT: begin
        if (b_fire) begin
          if (m_axi_bresp != 2'b00)               state_d = ERROR;
          else if (m_axi_wdata == STOP_SIGNATURE) state_d = DONE;
          else if (buffer_full)                   state_d = ERROR;
          else                                    state_d = COLLECT;
        end
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) state_q <= COLLECT;
    else                state_q <= state_d;
  end

  // Registered outputs, byte assembly and write bookkeeping; status flags and
  // ready signals follow the upcoming state so they never depend on rx_valid
  // combinationally.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      rx_ready      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awaddr  <= 32'd0;
      m_axi_wdata   <= 32'd0;
      loader_done   <= 1'b0;
      loader_error  <= 1'b0;
      word_count    <= 16'd0;
      byte_cnt      <= 2'd0;
      word_buf      <= 24'd0;
    end else begin
      rx_ready     <= (state_d == COLLECT);
      m_axi_bready <= (state_d == B_WAIT);
      loader_done  <= (state_d == DONE);
      loader_error <= (state_d == ERROR);

      if (rx_fire) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= rx_data;
          2'd1: word_buf[15:8]  <= rx_data;
          2'd2: word_buf[23:16] <= rx_data;
          default: begin
            m_axi_wdata  <= {rx_data, word_buf};
            m_axi_awaddr <= BASE_ADDR + {14'd0, word_count, 2'b00};
          end
        endcase
      end

      // Each channel drops its own valid after its own handshake.
      if (enter_write) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end else begin
        if (aw_fire) m_axi_awvalid <= 1'b0;
        if (w_fire)  m_axi_wvalid  <= 1'b0;
      end

      if (b_fire && (m_axi_bresp == 2'b00)) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader. A second instance built with
// MAX_WORDS=2 shares every input with the main instance and runs in lockstep
// until it reaches its buffer limit.
module tb_uart_boot_loader;

  logic        clk;
  logic        aresetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        done;
  logic        error;
  logic [15:0] wc;

  logic        d2_rx_ready;
  logic [31:0] d2_awaddr;
  logic        d2_awvalid;
  logic [31:0] d2_wdata;
  logic [3:0]  d2_wstrb;
  logic        d2_wvalid;
  logic        d2_bready;
  logic        d2_done;
  logic        d2_error;
  logic [15:0] d2_wc;

  int tests = 0;
  int fails = 0;

  // slave configuration
  int         aw_delay = 0;
  int         w_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_wait = 0;
  int         w_wait  = 0;

  // monitor results
  int          aw_n = 0;
  int          w_n  = 0;
  int          b_n  = 0;
  logic [31:0] aw_log [16];
  logic [31:0] w_log  [16];
  bit          aw_bad = 0;
  bit          w_bad  = 0;
  bit          strb_bad = 0;
  bit          ls_bad = 0;
  bit          aw_hold = 0;
  bit          w_hold  = 0;
  logic [31:0] aw_prev = 32'd0;
  logic [31:0] w_prev  = 32'd0;

  uart_boot_loader u_dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (aresetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .loader_done   (done),
    .loader_error  (error),
    .word_count    (wc)
  );

  uart_boot_loader #(.MAX_WORDS(2)) u_dut2 (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (aresetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (d2_rx_ready),
    .m_axi_awaddr  (d2_awaddr),
    .m_axi_awvalid (d2_awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (d2_wdata),
    .m_axi_wstrb   (d2_wstrb),
    .m_axi_wvalid  (d2_wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (d2_bready),
    .loader_done   (d2_done),
    .loader_error  (d2_error),
    .word_count    (d2_wc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AXI slave: readies after a configurable wait, B once both AW and W of a word arrived.
  always @(negedge clk) begin
    if (!aresetn) begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = 2'b00;
      aw_wait = 0;
      w_wait  = 0;
    end else begin
      if (awvalid) begin
        if (aw_wait >= aw_delay) awready = 1'b1;
        else begin awready = 1'b0; aw_wait++; end
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
      if (wvalid) begin
        if (w_wait >= w_delay) wready = 1'b1;
        else begin wready = 1'b0; w_wait++; end
      end else begin
        wready = 1'b0;
        w_wait = 0;
      end
      bvalid = (aw_n > b_n) && (w_n > b_n);
      bresp  = bresp_cfg;
    end
  end

  // Handshake monitor: logs transfers and flags unstable payloads or lockstep divergence.
  always @(posedge clk) begin
    if (!aresetn) begin
      aw_n = 0; w_n = 0; b_n = 0;
      aw_bad = 0; w_bad = 0; strb_bad = 0; ls_bad = 0;
      aw_hold = 0; w_hold = 0;
    end else begin
      if (awvalid && aw_hold && (awaddr !== aw_prev)) aw_bad = 1;
      if (wvalid && w_hold && (wdata !== w_prev)) w_bad = 1;
      aw_hold = awvalid && !awready;
      w_hold  = wvalid && !wready;
      aw_prev = awaddr;
      w_prev  = wdata;
      if (awvalid && awready) begin
        if (aw_n < 16) aw_log[aw_n] = awaddr;
        aw_n++;
      end
      if (wvalid && wready) begin
        if (w_n < 16) w_log[w_n] = wdata;
        if (wstrb !== 4'hF) strb_bad = 1;
        w_n++;
      end
      if (bvalid && bready) b_n++;
      if (!d2_error &&
          ({d2_rx_ready, d2_awaddr, d2_awvalid, d2_wdata, d2_wstrb, d2_wvalid, d2_bready, d2_done, d2_wc} !==
           {rx_ready, awaddr, awvalid, wdata, wstrb, wvalid, bready, done, wc}))
        ls_bad = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < budget; i++) begin
      if (rx_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    bit okb;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], 60, okb);
      ok = ok && okb;
    end
  endtask

  task automatic wait_b(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_n >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    tests++; if (bready !== 1'b0) begin fails++; $display("FAIL reset_bready: got %b want 0", bready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    tests++; if (wc !== 16'd0) begin fails++; $display("FAIL reset_word_count: got %0d want 0", wc); end
    tests++; if (awaddr !== 32'd0) begin fails++; $display("FAIL reset_awaddr: got %h want 0", awaddr); end
    tests++; if (wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    tests++; if (wstrb !== 4'hF) begin fails++; $display("FAIL reset_wstrb: got %h want f", wstrb); end
    aresetn = 1'b1;
    @(negedge clk);
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL post_reset_rx_ready: got %b want 1", rx_ready); end
  endtask

  task automatic test_single_word();
    bit ok;
    do_reset();
    aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
    send_word(32'h12345678, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_accept: got %b want 1", ok); end
    tests++; if (awvalid !== 1'b1) begin fails++; $display("FAIL single_awvalid: got %b want 1", awvalid); end
    tests++; if (wvalid !== 1'b1) begin fails++; $display("FAIL single_wvalid: got %b want 1", wvalid); end
    tests++; if (awaddr !== 32'h0000_2000) begin fails++; $display("FAIL single_awaddr: got %h want 00002000", awaddr); end
    tests++; if (wdata !== 32'h12345678) begin fails++; $display("FAIL single_wdata: got %h want 12345678", wdata); end
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL single_rx_ready_write: got %b want 0", rx_ready); end
    wait_b(1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_b_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    tests++; if (aw_n !== 1) begin fails++; $display("FAIL single_aw_count: got %0d want 1", aw_n); end
    tests++; if (w_n !== 1) begin fails++; $display("FAIL single_w_count: got %0d want 1", w_n); end
    tests++; if (aw_log[0] !== 32'h0000_2000) begin fails++; $display("FAIL single_aw_log: got %h want 00002000", aw_log[0]); end
    tests++; if (w_log[0] !== 32'h12345678) begin fails++; $display("FAIL single_w_log: got %h want 12345678", w_log[0]); end
    tests++; if (wc !== 16'd1) begin fails++; $display("FAIL single_word_count: got %0d want 1", wc); end
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL single_back_to_collect: got %b want 1", rx_ready); end
    tests++; if ({done, error} !== 2'b00) begin fails++; $display("FAIL single_flags: got %b want 00", {done, error}); end
    tests++; if (strb_bad !== 1'b0) begin fails++; $display("FAIL single_wstrb: got %b want 0", strb_bad); end
  endtask

  task automatic test_stream_stop();
    bit ok;
    bit okw;
    do_reset();
    ok = 1'b1;
    send_word(32'hAAAA5555, okw); ok = ok && okw;
    send_word(32'hDEADBEEF, okw); ok = ok && okw;
    send_word(32'hBDEDE000, okw); ok = ok && okw;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stream_accept: got %b want 1", ok); end
    wait_b(3, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stream_b_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    tests++; if (aw_n !== 3) begin fails++; $display("FAIL stream_aw_count: got %0d want 3", aw_n); end
    tests++; if (aw_log[0] !== 32'h2000) begin fails++; $display("FAIL stream_addr0: got %h want 00002000", aw_log[0]); end
    tests++; if (aw_log[1] !== 32'h2004) begin fails++; $display("FAIL stream_addr1: got %h want 00002004", aw_log[1]); end
    tests++; if (aw_log[2] !== 32'h2008) begin fails++; $display("FAIL stream_addr2: got %h want 00002008", aw_log[2]); end
    tests++; if (w_log[0] !== 32'hAAAA5555) begin fails++; $display("FAIL stream_data0: got %h want aaaa5555", w_log[0]); end
    tests++; if (w_log[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL stream_data1: got %h want deadbeef", w_log[1]); end
    tests++; if (w_log[2] !== 32'hBDEDE000) begin fails++; $display("FAIL stream_data2: got %h want bdede000", w_log[2]); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stream_done: got %b want 1", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL stream_error: got %b want 0", error); end
    tests++; if (wc !== 16'd3) begin fails++; $display("FAIL stream_word_count: got %0d want 3", wc); end
    tests++; if ({rx_ready, awvalid, wvalid, bready} !== 4'b0000) begin fails++; $display("FAIL stream_idle_outputs: got %b want 0000", {rx_ready, awvalid, wvalid, bready}); end
    send_byte(8'h5A, 10, ok);
    tests++; if (ok !== 1'b0) begin fails++; $display("FAIL stream_byte_after_done: got %b want 0", ok); end
    repeat (5) @(negedge clk);
    tests++; if (aw_n !== 3) begin fails++; $display("FAIL stream_no_more_writes: got %0d want 3", aw_n); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stream_done_held: got %b want 1", done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit okw;
    do_reset();
    ok = 1'b1;
    aw_delay = 3; w_delay = 0;
    send_word(32'h11223344, okw); ok = ok && okw;
    wait_b(1, okw); ok = ok && okw;
    aw_delay = 0; w_delay = 3;
    send_word(32'h55667788, okw); ok = ok && okw;
    wait_b(2, okw); ok = ok && okw;
    w_delay = 0;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_progress: got %b want 1", ok); end
    repeat (3) @(negedge clk);
    tests++; if (aw_n !== 2) begin fails++; $display("FAIL bp_aw_count: got %0d want 2", aw_n); end
    tests++; if (w_n !== 2) begin fails++; $display("FAIL bp_w_count: got %0d want 2", w_n); end
    tests++; if (aw_log[1] !== 32'h2004) begin fails++; $display("FAIL bp_addr1: got %h want 00002004", aw_log[1]); end
    tests++; if (w_log[0] !== 32'h11223344) begin fails++; $display("FAIL bp_data0: got %h want 11223344", w_log[0]); end
    tests++; if (w_log[1] !== 32'h55667788) begin fails++; $display("FAIL bp_data1: got %h want 55667788", w_log[1]); end
    tests++; if (aw_bad !== 1'b0) begin fails++; $display("FAIL bp_awaddr_stable: got %b want 0", aw_bad); end
    tests++; if (w_bad !== 1'b0) begin fails++; $display("FAIL bp_wdata_stable: got %b want 0", w_bad); end
    tests++; if (wc !== 16'd2) begin fails++; $display("FAIL bp_word_count: got %0d want 2", wc); end
  endtask

  task automatic test_max_words();
    bit ok;
    bit okw;
    do_reset();
    ok = 1'b1;
    send_word(32'h01020304, okw); ok = ok && okw;
    send_word(32'h05060708, okw); ok = ok && okw;
    wait_b(2, okw); ok = ok && okw;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL max_progress: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    tests++; if (d2_error !== 1'b1) begin fails++; $display("FAIL max_error: got %b want 1", d2_error); end
    tests++; if (d2_wc !== 16'd2) begin fails++; $display("FAIL max_word_count: got %0d want 2", d2_wc); end
    tests++; if ({d2_done, d2_rx_ready} !== 2'b00) begin fails++; $display("FAIL max_done_ready: got %b want 00", {d2_done, d2_rx_ready}); end
    tests++; if (ls_bad !== 1'b0) begin fails++; $display("FAIL max_lockstep: got %b want 0", ls_bad); end
    tests++; if ({error, rx_ready} !== 2'b01) begin fails++; $display("FAIL max_default_instance: got %b want 01", {error, rx_ready}); end
  endtask

  task automatic test_bad_resp();
    bit ok;
    do_reset();
    bresp_cfg = 2'b10;
    send_word(32'h0BADF00D, ok);
    wait_b(1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL badresp_b_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    bresp_cfg = 2'b00;
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL badresp_error: got %b want 1", error); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL badresp_done: got %b want 0", done); end
    tests++; if (wc !== 16'd0) begin fails++; $display("FAIL badresp_word_count: got %0d want 0", wc); end
    tests++; if ({rx_ready, bready} !== 2'b00) begin fails++; $display("FAIL badresp_ready: got %b want 00", {rx_ready, bready}); end
    send_byte(8'h11, 10, ok);
    tests++; if (ok !== 1'b0) begin fails++; $display("FAIL badresp_byte_refused: got %b want 0", ok); end
    repeat (5) @(negedge clk);
    tests++; if (aw_n !== 1) begin fails++; $display("FAIL badresp_no_more_writes: got %0d want 1", aw_n); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit okw;
    do_reset();
    aw_delay = 6; w_delay = 6;
    send_word(32'h99887766, ok);
    tests++; if (awvalid !== 1'b1) begin fails++; $display("FAIL abort_awvalid_before: got %b want 1", awvalid); end
    aresetn = 1'b0;
    @(negedge clk);
    tests++; if ({awvalid, wvalid, bready, rx_ready} !== 4'b0000) begin fails++; $display("FAIL abort_valids: got %b want 0000", {awvalid, wvalid, bready, rx_ready}); end
    tests++; if (awaddr !== 32'd0) begin fails++; $display("FAIL abort_awaddr: got %h want 0", awaddr); end
    tests++; if (wdata !== 32'd0) begin fails++; $display("FAIL abort_wdata: got %h want 0", wdata); end
    aresetn = 1'b1;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    ok = 1'b1;
    send_byte(8'hAA, 20, okw); ok = ok && okw;
    send_byte(8'hBB, 20, okw); ok = ok && okw;
    do_reset();
    send_word(32'hCAFEF00D, okw); ok = ok && okw;
    wait_b(1, okw); ok = ok && okw;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL abort_restart_progress: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    tests++; if (aw_n !== 1) begin fails++; $display("FAIL abort_aw_count: got %0d want 1", aw_n); end
    tests++; if (aw_log[0] !== 32'h2000) begin fails++; $display("FAIL abort_restart_addr: got %h want 00002000", aw_log[0]); end
    tests++; if (w_log[0] !== 32'hCAFEF00D) begin fails++; $display("FAIL abort_restart_data: got %h want cafef00d", w_log[0]); end
    tests++; if (wc !== 16'd1) begin fails++; $display("FAIL abort_word_count: got %0d want 1", wc); end
  endtask

  initial begin
    aresetn  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_single_word();
    test_stream_stop();
    test_backpressure();
    test_max_words();
    test_bad_resp();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
